// File: rtl/pe_lut_mac_if.sv
// Bus bundle for one systolic PE: operand/marker inputs, forwarded
// operands to the neighbour, live accumulator and the result handshake.
interface pe_lut_mac_if #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_WIDTH = 20
);
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_a;
  logic [DATA_SIZE-1:0] in_b;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic [DATA_SIZE-1:0] out_a;
  logic [DATA_SIZE-1:0] out_b;
  logic                 out_first;
  logic                 out_last;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 res_valid;
  logic                 res_ready;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 res_sat;
  logic                 res_overrun;

  // Upstream feeder / collector side
  modport master (
    output in_valid, in_a, in_b, in_first, in_last, res_ready,
    input  out_valid, out_a, out_b, out_first, out_last, acc_out,
           res_valid, res_data, res_sat, res_overrun
  );

  // Processing element side
  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, res_ready,
    output out_valid, out_a, out_b, out_first, out_last, acc_out,
           res_valid, res_data, res_sat, res_overrun
  );
endinterface

// File: rtl/pe_lut_mac.sv
// Output-stationary systolic PE: forwards A/B one stage, multiplies with a
// DIGIT x DIGIT partial-product table, accumulates a first/last framed dot
// product and hands each result to a one-entry valid/ready register.
module pe_lut_mac #(
  parameter int DATA_SIZE = 8,
  parameter int DIGIT     = 4,
  parameter int ACC_WIDTH = 20,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 0
) (
  input  logic         clk,
  input  logic         reset,
  pe_lut_mac_if.slave  bus
);
  localparam int ND = DATA_SIZE / DIGIT;
  localparam int NV = 1 << DIGIT;
  localparam int PW = 2 * DATA_SIZE;
  localparam int SW = ACC_WIDTH + 1;

  // Table entries are built by repeated addition at elaboration time.
  function automatic int tbl_prod(input int i, input int j);
    int p;
    p = 0;
    for (int k = 0; k < j; k++) p += i;
    return p;
  endfunction

  logic [2*DIGIT-1:0] lut [NV][NV];

  for (genvar gi = 0; gi < NV; gi++) begin : g_row
    for (genvar gj = 0; gj < NV; gj++) begin : g_col
      localparam int PV = tbl_prod(gi, gj);
      assign lut[gi][gj] = PV[2*DIGIT-1:0];
    end
  end

  logic                 a_neg, b_neg;
  logic [DATA_SIZE-1:0] mag_a, mag_b;
  logic [PW-1:0]        mag_p, prod;
  logic [SW-1:0]        prod_ext, base, sum;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic                 sat, sat_next, ovf;

  // Stage 1: the forwarded registers double as the multiplier operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_first <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_a     <= '0;
      bus.out_b     <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      bus.out_first <= bus.in_valid & bus.in_first;
      bus.out_last  <= bus.in_valid & bus.in_last;
      if (bus.in_valid) begin
        bus.out_a <= bus.in_a;
        bus.out_b <= bus.in_b;
      end
    end
  end

  // Sign-magnitude product from table partial products, extended to SW bits.
  always_comb begin
    a_neg = (SIGNED != 0) && bus.out_a[DATA_SIZE-1];
    b_neg = (SIGNED != 0) && bus.out_b[DATA_SIZE-1];
    mag_a = a_neg ? -bus.out_a : bus.out_a;
    mag_b = b_neg ? -bus.out_b : bus.out_b;
    mag_p = '0;
    for (int i = 0; i < ND; i++) begin
      for (int j = 0; j < ND; j++) begin
        mag_p = mag_p + (PW'(lut[mag_a[i*DIGIT +: DIGIT]][mag_b[j*DIGIT +: DIGIT]])
                         << ((i + j) * DIGIT));
      end
    end
    prod = (a_neg ^ b_neg) ? -mag_p : mag_p;
    if (SIGNED != 0) prod_ext = {{(SW-PW){prod[PW-1]}}, prod};
    else             prod_ext = {{(SW-PW){1'b0}}, prod};
  end

  // Next accumulator: restart on first, add, then clamp or wrap.
  always_comb begin
    base     = bus.out_first ? '0 : {(SIGNED != 0) && acc[ACC_WIDTH-1], acc};
    sum      = base + prod_ext;
    acc_next = sum[ACC_WIDTH-1:0];
    ovf      = 1'b0;
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        ovf = sum[SW-1] ^ sum[SW-2];
        if (ovf) acc_next = sum[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        ovf = sum[SW-1];
        if (ovf) acc_next = '1;
      end
    end
    sat_next = (bus.out_first ? 1'b0 : sat) | ovf;
  end

  assign bus.acc_out = acc;

  // Stage 2: accumulator update and the one-entry result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc             <= '0;
      sat             <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_sat     <= 1'b0;
      bus.res_overrun <= 1'b0;
    end else begin
      if (bus.out_valid) begin
        acc <= acc_next;
        sat <= sat_next;
      end
      if (bus.out_valid && bus.out_last) begin
        bus.res_data  <= acc_next;
        bus.res_sat   <= sat_next;
        bus.res_valid <= 1'b1;
        if (bus.res_valid && !bus.res_ready) bus.res_overrun <= 1'b1;
      end else if (bus.res_valid && bus.res_ready) begin
        bus.res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_lut_mac.sv
// Four PEs (unsigned/20, signed/20, signed-saturating/16, signed-wrapping/16)
// share one stimulus stream; a scoreboard queue holds each expected result.
module tb_pe_lut_mac;
  logic       clk, reset;
  logic       in_valid, in_first, in_last, res_ready;
  logic [7:0] in_a, in_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int d[4]; bit s2; } exp_t;
  exp_t exp_q[$];

  pe_lut_mac_if #(.DATA_SIZE(8), .ACC_WIDTH(20)) if0();
  pe_lut_mac_if #(.DATA_SIZE(8), .ACC_WIDTH(20)) if1();
  pe_lut_mac_if #(.DATA_SIZE(8), .ACC_WIDTH(16)) if2();
  pe_lut_mac_if #(.DATA_SIZE(8), .ACC_WIDTH(16)) if3();

  assign if0.in_valid = in_valid; assign if0.in_a = in_a; assign if0.in_b = in_b;
  assign if0.in_first = in_first; assign if0.in_last = in_last; assign if0.res_ready = res_ready;
  assign if1.in_valid = in_valid; assign if1.in_a = in_a; assign if1.in_b = in_b;
  assign if1.in_first = in_first; assign if1.in_last = in_last; assign if1.res_ready = res_ready;
  assign if2.in_valid = in_valid; assign if2.in_a = in_a; assign if2.in_b = in_b;
  assign if2.in_first = in_first; assign if2.in_last = in_last; assign if2.res_ready = res_ready;
  assign if3.in_valid = in_valid; assign if3.in_a = in_a; assign if3.in_b = in_b;
  assign if3.in_first = in_first; assign if3.in_last = in_last; assign if3.res_ready = res_ready;

  pe_lut_mac #(.DATA_SIZE(8), .DIGIT(4), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(0))
    u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  pe_lut_mac #(.DATA_SIZE(8), .DIGIT(4), .ACC_WIDTH(20), .SIGNED(1), .SATURATE(0))
    u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  pe_lut_mac #(.DATA_SIZE(8), .DIGIT(4), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1))
    u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  pe_lut_mac #(.DATA_SIZE(8), .DIGIT(4), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0))
    u3 (.clk(clk), .reset(reset), .bus(if3.slave));

  int   rd [4];
  logic rv [4];
  logic rs [4];
  assign rd[0] = int'(if0.res_data);
  assign rd[1] = int'($signed(if1.res_data));
  assign rd[2] = int'($signed(if2.res_data));
  assign rd[3] = int'($signed(if3.res_data));
  assign rv[0] = if0.res_valid; assign rv[1] = if1.res_valid;
  assign rv[2] = if2.res_valid; assign rv[3] = if3.res_valid;
  assign rs[0] = if0.res_sat;   assign rs[1] = if1.res_sat;
  assign rs[2] = if2.res_sat;   assign rs[3] = if3.res_sat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d0, input int d1, input int d2, input int d3, input bit s2);
    exp_t e;
    e.d  = '{d0, d1, d2, d3};
    e.s2 = s2;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  // Monitor: every accepted result is checked against the queue head.
  always @(negedge clk) begin
    if (!reset && if0.res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected result", rd[0], -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("res_valid u%0d", k), int'(rv[k]), 1);
          chk($sformatf("res_data u%0d", k), rd[k], e.d[k]);
          chk($sformatf("res_sat u%0d", k), int'(rs[k]), (k == 2) ? int'(e.s2) : 0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; res_ready = 1'b1;
    idle(2);
    chk("reset out_valid", int'(if0.out_valid), 0);
    chk("reset out_a", int'(if0.out_a), 0);
    chk("reset out_b", int'(if0.out_b), 0);
    chk("reset out_first", int'(if0.out_first), 0);
    chk("reset out_last", int'(if0.out_last), 0);
    chk("reset acc_out", int'(if0.acc_out), 0);
    chk("reset res_valid", int'(if0.res_valid), 0);
    chk("reset res_data", int'(if0.res_data), 0);
    chk("reset res_sat", int'(if0.res_sat), 0);
    chk("reset res_overrun", int'(if0.res_overrun), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("idle acc_out", int'(if0.acc_out), 0);
      chk("idle res_valid", int'(if0.res_valid), 0);
    end

    // Unsigned three-element dot product with forwarding checks
    send(8'd2, 8'd3, 1'b1, 1'b0);
    chk("fwd out_a 2", int'(if0.out_a), 2);
    chk("fwd out_b 3", int'(if0.out_b), 3);
    chk("fwd out_first", int'(if0.out_first), 1);
    send(8'd4, 8'd5, 1'b0, 1'b0);
    chk("acc 6", int'(if0.acc_out), 6);
    chk("fwd out_a 4", int'(if0.out_a), 4);
    chk("fwd out_b 5", int'(if0.out_b), 5);
    push(68, 68, 68, 68, 1'b0);
    send(8'd6, 8'd7, 1'b0, 1'b1);
    chk("acc 26", int'(if0.acc_out), 26);
    chk("fwd out_last", int'(if0.out_last), 1);
    idle(1);
    chk("acc 68", int'(if0.acc_out), 68);
    chk("res_valid at +2", int'(if0.res_valid), 1);
    chk("res_data 68", rd[0], 68);
    chk("out_a holds", int'(if0.out_a), 6);
    idle(2);

    // Single-element signed edge cases, back to back
    push(1771, -21, -21, -21, 1'b0);
    send(8'd253, 8'd7, 1'b1, 1'b1);
    push(16384, 16384, 16384, 16384, 1'b0);
    send(8'd128, 8'd128, 1'b1, 1'b1);
    push(65025, 1, 1, 1, 1'b0);
    send(8'd255, 8'd255, 1'b1, 1'b1);
    idle(3);

    // Saturation vs wrap, then a fresh dot product clears res_sat
    send(8'd127, 8'd127, 1'b1, 1'b0);
    send(8'd127, 8'd127, 1'b0, 1'b0);
    push(48387, 48387, 32767, -17149, 1'b1);
    send(8'd127, 8'd127, 1'b0, 1'b1);
    push(1, 1, 1, 1, 1'b0);
    send(8'd1, 8'd1, 1'b1, 1'b1);
    idle(3);

    // Overrun: two results with no ready, then ready as a third arrives
    res_ready = 1'b0;
    send(8'd5, 8'd1, 1'b1, 1'b1);
    push(9, 9, 9, 9, 1'b0);
    send(8'd3, 8'd3, 1'b1, 1'b1);
    idle(1);
    chk("held res_data 9", rd[0], 9);
    chk("held res_valid", int'(if0.res_valid), 1);
    chk("res_overrun u0", int'(if0.res_overrun), 1);
    chk("res_overrun u2", int'(if2.res_overrun), 1);
    push(4, 4, 4, 4, 1'b0);
    send(8'd2, 8'd2, 1'b1, 1'b1);
    res_ready = 1'b1;
    idle(1);
    chk("res_valid stays", int'(if0.res_valid), 1);
    chk("res_data 4", rd[0], 4);
    chk("overrun sticky", int'(if0.res_overrun), 1);
    idle(2);
    chk("res_valid drained", int'(if0.res_valid), 0);

    // Reset in the middle of a dot product
    send(8'd1, 8'd1, 1'b1, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0);
    chk("acc before reset", int'(if0.acc_out), 1);
    reset = 1'b1;
    idle(1);
    chk("mid reset acc_out", int'(if0.acc_out), 0);
    chk("mid reset res_valid", int'(if0.res_valid), 0);
    chk("mid reset overrun", int'(if0.res_overrun), 0);
    reset = 1'b0;
    push(9, 9, 9, 9, 1'b0);
    send(8'd3, 8'd3, 1'b1, 1'b1);
    idle(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
